blk_stream_checker: RTL and testbench

Synthesizable self-check for row-serial 8x8 block streams. It buffers an expected stream (e.g. the input of a forward/inverse DCT chain) and compares it lane by lane, with a tolerance, against an actual stream (e.g. the chain output). It reports data, control and framing errors through saturating counters and sticky flags, for on-chip round-trip checking of the DCT path on FPGA and in simulation.

---
 rtl/blk_stream_checker.sv | 239 +++++++++++++++++++++++
 tb/tb_blk_stream_checker.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blk_stream_checker.sv
// blk_stream_checker: buffers an expected row-serial 8x8 block stream and
// compares it lane by lane (with tolerance) against an actual stream,
// accumulating data/control/framing error statistics.
module blk_stream_checker #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned W      = 8,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned TOL    = 1,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ROWS   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   exp_valid,
  input  logic [LANES*W-1:0]     exp_data,
  input  logic                   exp_eob,
  input  logic                   exp_sob,
  input  logic                   exp_sof,
  input  logic                   act_valid,
  input  logic [LANES*W-1:0]     act_data,
  input  logic                   act_eob,
  input  logic                   act_sob,
  input  logic                   act_sof,
  output logic [$clog2(DEPTH):0] level,
  output logic [31:0]            data_err_cnt,
  output logic [31:0]            ctrl_err_cnt,
  output logic [31:0]            frame_err_cnt,
  output logic [31:0]            row_cnt,
  output logic                   err_pulse,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   first_err_valid,
  output logic [31:0]            first_err_row,
  output logic [LANES-1:0]       first_err_lanes
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned DW = LANES * W;
  localparam int unsigned EW = DW + 3;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = $clog2(LANES + 1);

  typedef enum logic {S_IDLE, S_BLOCK} state_t;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // FIFO storage and pointers
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  // Statistics registers
  logic [31:0]       data_err_q, data_err_d, ctrl_err_q, ctrl_err_d;
  logic [31:0]       frame_err_q, frame_err_d, row_cnt_q, row_cnt_d;
  logic              err_pulse_q, err_pulse_d, overflow_q, overflow_d;
  logic              underflow_q, underflow_d, first_valid_q, first_valid_d;
  logic [31:0]       first_row_q, first_row_d;
  logic [LANES-1:0]  first_lanes_q, first_lanes_d;

  // Framing FSM
  state_t        state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [1:0]    frame_inc;

  // Decode and compare signals
  logic          exp_ok, act_ok, fifo_empty, fifo_full;
  logic          bypass_c, pop_c, push_c, drop_c, under_c, cmp_c;
  logic [EW-1:0] exp_entry, ref_entry;
  logic [DW-1:0] ref_data;
  logic [2:0]    ref_ctrl, act_ctrl;
  logic          ctrl_mis, row_err;
  logic [LANES-1:0] mask;
  logic [CW-1:0] pop_cnt;
  logic [W-1:0]  e_lane, a_lane;
  logic [W:0]    e_ext, a_ext, diff, mag;

  // Push/pop/bypass decode; rows in a clr cycle are ignored
  always_comb begin
    exp_ok     = exp_valid & ~clr;
    act_ok     = act_valid & ~clr;
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LW'(DEPTH));
    bypass_c   = fifo_empty & exp_ok & act_ok;
    pop_c      = act_ok & ~fifo_empty;
    push_c     = exp_ok & ~bypass_c & (~fifo_full | pop_c);
    drop_c     = exp_ok & fifo_full & ~pop_c;
    under_c    = act_ok & fifo_empty & ~exp_ok;
    cmp_c      = pop_c | bypass_c;
    exp_entry  = {exp_sof, exp_sob, exp_eob, exp_data};
    ref_entry  = fifo_empty ? exp_entry : mem_q[rd_ptr_q];
    ref_data   = ref_entry[DW-1:0];
    ref_ctrl   = ref_entry[EW-1:DW];
    act_ctrl   = {act_sof, act_sob, act_eob};
    ctrl_mis   = (ref_ctrl != act_ctrl);
  end

  // Per-lane |exp - act| > TOL in W+1 bits, plus mismatch popcount
  always_comb begin
    mask    = '0;
    pop_cnt = '0;
    e_lane  = '0;
    a_lane  = '0;
    e_ext   = '0;
    a_ext   = '0;
    diff    = '0;
    mag     = '0;
    for (int i = 0; i < LANES; i++) begin
      e_lane = ref_data[i*W +: W];
      a_lane = act_data[i*W +: W];
      if (SIGNED != 0) begin
        e_ext = {e_lane[W-1], e_lane};
        a_ext = {a_lane[W-1], a_lane};
      end else begin
        e_ext = {1'b0, e_lane};
        a_ext = {1'b0, a_lane};
      end
      diff    = e_ext - a_ext;
      mag     = diff[W] ? ((~diff) + (W+1)'(1)) : diff;
      mask[i] = (mag > (W+1)'(TOL));
      pop_cnt = pop_cnt + CW'(mask[i]);
    end
    row_err = (|mask) | ctrl_mis;
  end

  // Framing next-state logic on the actual stream
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    frame_inc = '0;
    if (act_ok) begin
      if (act_sof && !act_sob) frame_inc = frame_inc + 2'd1;
      if (act_sob) begin
        if (state_q == S_BLOCK) frame_inc = frame_inc + 2'd1;
        if (ROWS == 1) begin
          state_d = S_IDLE;
          r_d     = '0;
          if (!act_eob) frame_inc = frame_inc + 2'd1;
        end else if (act_eob) begin
          state_d   = S_IDLE;
          r_d       = '0;
          frame_inc = frame_inc + 2'd1;
        end else begin
          state_d = S_BLOCK;
          r_d     = RW'(1);
        end
      end else if (state_q == S_IDLE) begin
        frame_inc = frame_inc + 2'd1;
      end else if (r_q == RW'(ROWS - 1)) begin
        state_d = S_IDLE;
        r_d     = '0;
        if (!act_eob) frame_inc = frame_inc + 2'd1;
      end else if (act_eob) begin
        state_d   = S_IDLE;
        r_d       = '0;
        frame_inc = frame_inc + 2'd1;
      end else begin
        r_d = r_q + RW'(1);
      end
    end
  end

  // Pointer, level and statistics next-state
  always_comb begin
    wr_ptr_d      = push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d      = pop_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d       = level_q;
    if (push_c && !pop_c) level_d = level_q + LW'(1);
    if (pop_c && !push_c) level_d = level_q - LW'(1);
    data_err_d    = data_err_q;
    ctrl_err_d    = ctrl_err_q;
    row_cnt_d     = row_cnt_q;
    first_valid_d = first_valid_q;
    first_row_d   = first_row_q;
    first_lanes_d = first_lanes_q;
    if (cmp_c) begin
      data_err_d = sat_add(data_err_q, 32'(pop_cnt));
      ctrl_err_d = sat_add(ctrl_err_q, 32'(ctrl_mis));
      row_cnt_d  = sat_add(row_cnt_q, 32'd1);
      if (row_err && !first_valid_q) begin
        first_valid_d = 1'b1;
        first_row_d   = row_cnt_q;
        first_lanes_d = mask;
      end
    end
    frame_err_d = sat_add(frame_err_q, 32'(frame_inc));
    overflow_d  = overflow_q | drop_c;
    underflow_d = underflow_q | under_c;
    err_pulse_d = (cmp_c & row_err) | under_c | drop_c | (frame_inc != 2'd0);
  end

  // FIFO row storage (no reset needed; validity tracked by level)
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= exp_entry;
  end

  // State registers with async reset and synchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0; rd_ptr_q <= '0; level_q <= '0;
      data_err_q <= '0; ctrl_err_q <= '0; frame_err_q <= '0; row_cnt_q <= '0;
      err_pulse_q <= 1'b0; overflow_q <= 1'b0; underflow_q <= 1'b0;
      first_valid_q <= 1'b0; first_row_q <= '0; first_lanes_q <= '0;
      state_q <= S_IDLE; r_q <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0; rd_ptr_q <= '0; level_q <= '0;
      data_err_q <= '0; ctrl_err_q <= '0; frame_err_q <= '0; row_cnt_q <= '0;
      err_pulse_q <= 1'b0; overflow_q <= 1'b0; underflow_q <= 1'b0;
      first_valid_q <= 1'b0; first_row_q <= '0; first_lanes_q <= '0;
      state_q <= S_IDLE; r_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; level_q <= level_d;
      data_err_q <= data_err_d; ctrl_err_q <= ctrl_err_d;
      frame_err_q <= frame_err_d; row_cnt_q <= row_cnt_d;
      err_pulse_q <= err_pulse_d; overflow_q <= overflow_d; underflow_q <= underflow_d;
      first_valid_q <= first_valid_d; first_row_q <= first_row_d;
      first_lanes_q <= first_lanes_d;
      state_q <= state_d; r_q <= r_d;
    end
  end

  assign level           = level_q;
  assign data_err_cnt    = data_err_q;
  assign ctrl_err_cnt    = ctrl_err_q;
  assign frame_err_cnt   = frame_err_q;
  assign row_cnt         = row_cnt_q;
  assign err_pulse       = err_pulse_q;
  assign overflow        = overflow_q;
  assign underflow       = underflow_q;
  assign first_err_valid = first_valid_q;
  assign first_err_row   = first_row_q;
  assign first_err_lanes = first_lanes_q;

endmodule

// File: tb/tb_blk_stream_checker.sv
// Directed bench for blk_stream_checker: unsigned default instance plus a
// small signed instance.
module tb_blk_stream_checker;

  logic clk = 1'b0;
  logic rst, clr;
  logic exp_valid, exp_eob, exp_sob, exp_sof, act_valid, act_eob, act_sob, act_sof;
  logic [63:0] exp_data, act_data;
  logic [6:0]  level;
  logic [31:0] data_err_cnt, ctrl_err_cnt, frame_err_cnt, row_cnt, first_err_row;
  logic        err_pulse, overflow, underflow, first_err_valid;
  logic [7:0]  first_err_lanes;

  logic s_exp_valid, s_act_valid;
  logic [63:0] s_exp_data, s_act_data;
  logic [2:0]  s_level;
  logic [31:0] s_data_err_cnt, s_ctrl_err_cnt, s_frame_err_cnt, s_row_cnt, s_first_err_row;
  logic        s_err_pulse, s_overflow, s_underflow, s_first_err_valid;
  logic [7:0]  s_first_err_lanes;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  blk_stream_checker dut (
    .clk(clk), .rst(rst), .clr(clr),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_eob(exp_eob), .exp_sob(exp_sob), .exp_sof(exp_sof),
    .act_valid(act_valid), .act_data(act_data), .act_eob(act_eob), .act_sob(act_sob), .act_sof(act_sof),
    .level(level), .data_err_cnt(data_err_cnt), .ctrl_err_cnt(ctrl_err_cnt),
    .frame_err_cnt(frame_err_cnt), .row_cnt(row_cnt), .err_pulse(err_pulse),
    .overflow(overflow), .underflow(underflow), .first_err_valid(first_err_valid),
    .first_err_row(first_err_row), .first_err_lanes(first_err_lanes)
  );

  blk_stream_checker #(.SIGNED(1), .DEPTH(4)) dut_s (
    .clk(clk), .rst(rst), .clr(clr),
    .exp_valid(s_exp_valid), .exp_data(s_exp_data), .exp_eob(1'b0), .exp_sob(1'b0), .exp_sof(1'b0),
    .act_valid(s_act_valid), .act_data(s_act_data), .act_eob(1'b0), .act_sob(1'b0), .act_sof(1'b0),
    .level(s_level), .data_err_cnt(s_data_err_cnt), .ctrl_err_cnt(s_ctrl_err_cnt),
    .frame_err_cnt(s_frame_err_cnt), .row_cnt(s_row_cnt), .err_pulse(s_err_pulse),
    .overflow(s_overflow), .underflow(s_underflow), .first_err_valid(s_first_err_valid),
    .first_err_row(s_first_err_row), .first_err_lanes(s_first_err_lanes)
  );

  function automatic logic [63:0] fill(input logic [7:0] v);
    return {8{v}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_exp(input logic v, input logic [63:0] d, input logic sof, input logic sob, input logic eob);
    exp_valid = v; exp_data = d; exp_sof = sof; exp_sob = sob; exp_eob = eob;
  endtask

  task automatic drive_act(input logic v, input logic [63:0] d, input logic sof, input logic sob, input logic eob);
    act_valid = v; act_data = d; act_sof = sof; act_sob = sob; act_eob = eob;
  endtask

  task automatic idle();
    drive_exp(1'b0, '0, 1'b0, 1'b0, 1'b0);
    drive_act(1'b0, '0, 1'b0, 1'b0, 1'b0);
    s_exp_valid = 1'b0; s_act_valid = 1'b0; s_exp_data = '0; s_act_data = '0;
  endtask

  task automatic do_clr();
    idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    clr = 1'b0;
    rst = 1'b1;
    tick(); tick();
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if ({data_err_cnt, ctrl_err_cnt, frame_err_cnt, row_cnt} !== 128'd0) begin errors++; $display("FAIL reset_counters got %h want 0", {data_err_cnt, ctrl_err_cnt, frame_err_cnt, row_cnt}); end
    checks++; if ({err_pulse, overflow, underflow, first_err_valid} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {err_pulse, overflow, underflow, first_err_valid}); end
    checks++; if ({first_err_row, first_err_lanes} !== 40'd0) begin errors++; $display("FAIL reset_first_err got %h want 0", {first_err_row, first_err_lanes}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    int peak = 0;
    int pulses = 0;
    int a;
    do_clr();
    for (int t = 0; t < 170; t++) begin
      if (t < 160) drive_exp(1'b1, fill(8'hFF), t == 0, (t % 8) == 0, (t % 8) == 7);
      else         drive_exp(1'b0, '0, 1'b0, 1'b0, 1'b0);
      a = t - 10;
      if (t >= 10) drive_act(1'b1, fill(8'hFF), a == 0, (a % 8) == 0, (a % 8) == 7);
      else         drive_act(1'b0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      if (int'(level) > peak) peak = int'(level);
      if (err_pulse) pulses++;
    end
    idle();
    tick();
    checks++; if (row_cnt !== 32'd160) begin errors++; $display("FAIL stream_row_cnt got %0d want 160", row_cnt); end
    checks++; if ({data_err_cnt, ctrl_err_cnt, frame_err_cnt} !== 96'd0) begin errors++; $display("FAIL stream_err_cnts got %h want 0", {data_err_cnt, ctrl_err_cnt, frame_err_cnt}); end
    checks++; if (peak !== 10) begin errors++; $display("FAIL stream_level_peak got %0d want 10", peak); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL stream_err_pulses got %0d want 0", pulses); end
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL stream_level_end got %0d want 0", level); end
  endtask

  task automatic test_tolerance();
    logic [63:0] e, a;
    do_clr();
    for (int r = 0; r < 8; r++) begin
      e = '0; e[3*8 +: 8] = 8'd100; e[0 +: 8] = 8'd5;
      a = '0; a[3*8 +: 8] = (r == 5) ? 8'd102 : 8'd101; a[0 +: 8] = 8'd4;
      drive_exp(1'b1, e, r == 0, r == 0, r == 7);
      drive_act(1'b1, a, r == 0, r == 0, r == 7);
      tick();
      if (r == 4) begin
        checks++; if ({err_pulse, data_err_cnt} !== 33'd0) begin errors++; $display("FAIL tol_within got pulse=%b cnt=%0d want 0/0", err_pulse, data_err_cnt); end
      end
      if (r == 5) begin
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL tol_err_pulse got %b want 1", err_pulse); end
        checks++; if (data_err_cnt !== 32'd1) begin errors++; $display("FAIL tol_data_err got %0d want 1", data_err_cnt); end
        checks++; if ({first_err_valid, first_err_row, first_err_lanes} !== {1'b1, 32'd5, 8'b0000_1000}) begin errors++; $display("FAIL tol_first_err got v=%b row=%0d lanes=%b want 1/5/00001000", first_err_valid, first_err_row, first_err_lanes); end
      end
      if (r == 6) begin
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL tol_pulse_single got %b want 0", err_pulse); end
      end
    end
    idle();
    tick();
    checks++; if ({row_cnt, data_err_cnt, frame_err_cnt, 25'(level)} !== {32'd8, 32'd1, 32'd0, 25'd0}) begin errors++; $display("FAIL tol_end got rows=%0d data=%0d frame=%0d level=%0d want 8/1/0/0", row_cnt, data_err_cnt, frame_err_cnt, level); end
  endtask

  task automatic test_signed();
    logic [63:0] a;
    do_clr();
    s_exp_valid = 1'b1; s_act_valid = 1'b1;
    s_exp_data = fill(8'h80); s_act_data = fill(8'h7F);
    a = '0; a[0 +: 8] = 8'hFF;
    drive_exp(1'b1, '0, 1'b0, 1'b0, 1'b0);
    drive_act(1'b1, a, 1'b0, 1'b0, 1'b0);
    tick();
    s_exp_data = fill(8'h00); s_act_data = fill(8'hFF);
    idle();
    s_exp_valid = 1'b1; s_act_valid = 1'b1;
    s_exp_data = fill(8'h00); s_act_data = fill(8'hFF);
    tick();
    idle();
    tick();
    checks++; if (s_data_err_cnt !== 32'd8) begin errors++; $display("FAIL signed_data_err got %0d want 8", s_data_err_cnt); end
    checks++; if ({s_row_cnt, s_ctrl_err_cnt} !== {32'd2, 32'd0}) begin errors++; $display("FAIL signed_rows got rows=%0d ctrl=%0d want 2/0", s_row_cnt, s_ctrl_err_cnt); end
    checks++; if (data_err_cnt !== 32'd1) begin errors++; $display("FAIL unsigned_wrap got %0d want 1", data_err_cnt); end
  endtask

  task automatic test_overflow();
    do_clr();
    for (int i = 0; i < 65; i++) begin
      drive_exp(1'b1, fill(8'(i)), 1'b0, 1'b1, 1'b0);
      tick();
      if (i == 63) begin
        checks++; if ({overflow, level} !== {1'b0, 7'd64}) begin errors++; $display("FAIL ovf_full got ovf=%b level=%0d want 0/64", overflow, level); end
      end
    end
    checks++; if ({overflow, err_pulse, level} !== {1'b1, 1'b1, 7'd64}) begin errors++; $display("FAIL ovf_drop got ovf=%b pulse=%b level=%0d want 1/1/64", overflow, err_pulse, level); end
    drive_exp(1'b1, fill(8'hAA), 1'b0, 1'b1, 1'b0);
    drive_act(1'b1, fill(8'h00), 1'b0, 1'b1, 1'b0);
    tick();
    checks++; if ({level, row_cnt, data_err_cnt, err_pulse} !== {7'd64, 32'd1, 32'd0, 1'b0}) begin errors++; $display("FAIL ovf_push_pop got level=%0d rows=%0d data=%0d pulse=%b want 64/1/0/0", level, row_cnt, data_err_cnt, err_pulse); end
    do_clr();
    checks++; if ({overflow, underflow, level} !== 9'd0) begin errors++; $display("FAIL clr_flags got ovf=%b unf=%b level=%0d want 0/0/0", overflow, underflow, level); end
    drive_act(1'b1, fill(8'h00), 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    checks++; if ({underflow, err_pulse, row_cnt} !== {1'b1, 1'b1, 32'd0}) begin errors++; $display("FAIL underflow got unf=%b pulse=%b rows=%0d want 1/1/0", underflow, err_pulse, row_cnt); end
  endtask

  task automatic test_framing();
    logic sob;
    do_clr();
    for (int r = 0; r < 8; r++) begin
      sob = (r == 0) || (r == 3);
      drive_exp(1'b1, fill(8'(r)), r == 0, sob, 1'b0);
      drive_act(1'b1, fill(8'(r)), r == 0, sob, 1'b0);
      tick();
      if (r == 3) begin
        checks++; if (frame_err_cnt !== 32'd1) begin errors++; $display("FAIL frame_resob got %0d want 1", frame_err_cnt); end
      end
    end
    for (int r = 0; r < 8; r++) begin
      drive_exp(1'b1, fill(8'(r)), 1'b0, r == 0, r == 7);
      drive_act(1'b1, fill(8'(r)), 1'b0, r == 0, r == 7);
      tick();
    end
    checks++; if ({frame_err_cnt, ctrl_err_cnt, data_err_cnt, row_cnt} !== {32'd2, 32'd0, 32'd0, 32'd16}) begin errors++; $display("FAIL frame_cnt got frame=%0d ctrl=%0d data=%0d rows=%0d want 2/0/0/16", frame_err_cnt, ctrl_err_cnt, data_err_cnt, row_cnt); end
    for (int r = 0; r < 8; r++) begin
      drive_exp(1'b1, fill(8'h40), 1'b0, r == 0, 1'b0);
      drive_act(1'b1, fill(8'h40), 1'b0, r == 0, r == 7);
      tick();
    end
    idle();
    checks++; if ({ctrl_err_cnt, data_err_cnt, frame_err_cnt, err_pulse} !== {32'd1, 32'd0, 32'd2, 1'b1}) begin errors++; $display("FAIL ctrl_eob got ctrl=%0d data=%0d frame=%0d pulse=%b want 1/0/2/1", ctrl_err_cnt, data_err_cnt, frame_err_cnt, err_pulse); end
    checks++; if ({first_err_valid, first_err_row, first_err_lanes} !== {1'b1, 32'd23, 8'h00}) begin errors++; $display("FAIL ctrl_first_err got v=%b row=%0d lanes=%h want 1/23/00", first_err_valid, first_err_row, first_err_lanes); end
    tick();
  endtask

  task automatic test_reset_midblock();
    logic [63:0] a;
    do_clr();
    for (int r = 0; r < 4; r++) begin
      a = fill(8'(r));
      if (r == 2) a[8 +: 8] = 8'(r + 10);
      drive_exp(1'b1, fill(8'(r)), r == 0, r == 0, 1'b0);
      drive_act(1'b1, a, r == 0, r == 0, 1'b0);
      tick();
    end
    checks++; if (data_err_cnt !== 32'd1) begin errors++; $display("FAIL midrst_pre got %0d want 1", data_err_cnt); end
    drive_exp(1'b1, fill(8'd4), 1'b0, 1'b0, 1'b0);
    drive_act(1'b1, fill(8'd9), 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checks++; if ({data_err_cnt, row_cnt, frame_err_cnt, first_err_valid, err_pulse} !== 98'd0) begin errors++; $display("FAIL midrst_async got data=%0d rows=%0d frame=%0d v=%b pulse=%b want 0", data_err_cnt, row_cnt, frame_err_cnt, first_err_valid, err_pulse); end
    tick();
    rst = 1'b0;
    idle();
    tick();
    checks++; if ({row_cnt, data_err_cnt, 25'(level)} !== 89'd0) begin errors++; $display("FAIL midrst_after got rows=%0d data=%0d level=%0d want 0", row_cnt, data_err_cnt, level); end
    for (int r = 0; r < 8; r++) begin
      drive_exp(1'b1, fill(8'(r * 3)), r == 0, r == 0, r == 7);
      drive_act(1'b1, fill(8'(r * 3)), r == 0, r == 0, r == 7);
      tick();
    end
    idle();
    tick();
    checks++; if ({row_cnt, frame_err_cnt, data_err_cnt} !== {32'd8, 32'd0, 32'd0}) begin errors++; $display("FAIL midrst_clean got rows=%0d frame=%0d data=%0d want 8/0/0", row_cnt, frame_err_cnt, data_err_cnt); end
  endtask

  task automatic test_back_to_back();
    do_clr();
    drive_exp(1'b1, fill(8'h11), 1'b1, 1'b1, 1'b0);
    tick();
    checks++; if (level !== 7'd1) begin errors++; $display("FAIL b2b_push got level=%0d want 1", level); end
    drive_exp(1'b1, fill(8'h22), 1'b0, 1'b0, 1'b0);
    drive_act(1'b1, fill(8'h11), 1'b1, 1'b1, 1'b0);
    tick();
    checks++; if ({level, row_cnt, data_err_cnt, ctrl_err_cnt} !== {7'd1, 32'd1, 32'd0, 32'd0}) begin errors++; $display("FAIL b2b_pop1 got level=%0d rows=%0d data=%0d ctrl=%0d want 1/1/0/0", level, row_cnt, data_err_cnt, ctrl_err_cnt); end
    drive_exp(1'b1, 64'h1716151413121110, 1'b0, 1'b0, 1'b0);
    drive_act(1'b1, fill(8'h22), 1'b0, 1'b0, 1'b0);
    tick();
    drive_exp(1'b0, '0, 1'b0, 1'b0, 1'b0);
    drive_act(1'b1, 64'h1516151413121112, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    checks++; if ({level, row_cnt, data_err_cnt} !== {7'd0, 32'd3, 32'd2}) begin errors++; $display("FAIL b2b_order got level=%0d rows=%0d data=%0d want 0/3/2", level, row_cnt, data_err_cnt); end
    checks++; if ({first_err_row, first_err_lanes} !== {32'd2, 8'h81}) begin errors++; $display("FAIL b2b_first_err got row=%0d lanes=%h want 2/81", first_err_row, first_err_lanes); end
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_tolerance();
    test_signed();
    test_overflow();
    test_framing();
    test_reset_midblock();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
